fp_accum: RTL and testbench
===========================

FP_ACCUM -- requirements
Module: fp_accum

Interface
REQ-001 SHALL have parameter N, default 32, IEEE-754 word width; legal values 32 (8/23 split) and 64 (11/52 split).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  product word presented, typically from the fmul stage.
REQ-005 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-006 SHALL have port in_data  input  N  IEEE-754 operand to add into the accumulator.
REQ-007 SHALL have port in_last  input  1  final operand of the current sum; sampled with in_data.
REQ-008 SHALL have port out_valid  output  1  out_data holds the finished sum.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_data.
REQ-010 SHALL have port out_data  output  N  accumulated IEEE-754 result.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, DONE.
REQ-013 in_ready SHALL be high only in IDLE; in_valid&in_ready captures in_data and in_last, then IDLE->ALIGN.
REQ-014 ALIGN SHALL order accumulator and operand by exponent, then right-shift the smaller significand (hidden 1 restored) into guard/round/sticky; shift >= man+4 leaves only sticky.
REQ-015 ADD SHALL add significands when signs match, else subtract smaller magnitude from larger; result sign is that of the larger magnitude.
REQ-016 NORM SHALL normalise (1-bit right shift on carry-out, left shift by leading-zero count otherwise), round to nearest, ties to even, update the accumulator, then go to DONE if in_last was set, else to IDLE.
REQ-017 Per-operand latency SHALL be exactly 4 cycles from acceptance to the next in_ready (or out_valid).
REQ-018 DONE SHALL assert out_valid with out_data stable until out_ready; on the handshake the accumulator clears to +0 and the FSM returns to IDLE.
REQ-019 Operands with exponent field zero SHALL be treated as zero (denormals flushed); zero operand leaves the accumulator unchanged but still takes 4 cycles.
REQ-020 Exact cancellation SHALL yield +0 (0x0...0).
REQ-021 A biased exponent reaching all-ones after normalisation SHALL saturate to signed infinity; below 1 SHALL flush to signed zero.
REQ-022 NaN/infinity inputs are outside scope; result is unspecified but the FSM SHALL still follow REQ-013..REQ-018.
REQ-023 Internal significand datapath SHALL be man+5 bits (carry, hidden, mantissa, guard, round, sticky).

Reset
REQ-024 rst SHALL immediately force IDLE, accumulator +0, in_ready 1, out_valid 0, out_data 0, busy 0, regardless of state.
REQ-025 An operand or result in flight at reset SHALL be discarded; no output handshake follows.

Structure
REQ-026 Package fp_pkg SHALL hold the per-N constants (exp_len, man_len, bias, enc_len) and the FSM state enum; the fmul stage SHALL share the same package.
REQ-027 Leading-zero count SHALL be a sub-module lzc, parameterised by input width, output enc_len bits.
REQ-028 Implementation SHALL be synchronous RTL, no latches, one always_ff for state/registers.

Verification
REQ-029 0x3F800000 (1.0), then 0x40000000 (2.0) with in_last -> out_valid 8 cycles after first acceptance, out_data 0x40400000.
REQ-030 0x3FC00000 (1.5), then 0xBFC00000 (-1.5) last -> out_data 0x00000000.
REQ-031 0x4B800000 (2^24), then 0x3F800000 (1.0) last -> tie rounds to even, out_data 0x4B800000.
REQ-032 0x7F7FFFFF twice, last on second -> out_data 0x7F800000.
REQ-033 out_ready held low 10 cycles in DONE -> out_valid and out_data stable, in_ready low; release -> one handshake, next sum starts from +0.
REQ-034 rst pulsed during ALIGN of second operand -> all outputs at reset values next cycle; new sum 0x40000000 last -> 0x40000000.

Source files
------------

// File: rtl/fp_pkg.sv
// IEEE-754 format constants shared by the fmul and accumulate stages, plus the
// accumulator FSM encoding.
package fp_pkg;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  function automatic int unsigned exp_len(input int unsigned n);
    return (n == 32'd64) ? 32'd11 : 32'd8;
  endfunction

  function automatic int unsigned man_len(input int unsigned n);
    return (n == 32'd64) ? 32'd52 : 32'd23;
  endfunction

  function automatic int unsigned bias(input int unsigned n);
    return (32'd1 << (exp_len(n) - 32'd1)) - 32'd1;
  endfunction

  // Wide enough to hold a leading-zero count of 0..man+5.
  function automatic int unsigned enc_len(input int unsigned n);
    return $clog2(man_len(n) + 32'd6);
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module lzc #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned ENC   = 5
) (
  input  logic [WIDTH-1:0] din,
  output logic [ENC-1:0]   cnt_c
);

  logic found;

  always_comb begin
    cnt_c = ENC'(WIDTH);
    found = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!found && din[i]) begin
        cnt_c = ENC'(int'(WIDTH) - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_accum.sv
// Sequential IEEE-754 accumulator: one operand per 4 cycles, round-to-nearest-even,
// denormals flushed, result handed out on a valid/ready port after in_last.
module fp_accum
  import fp_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int unsigned E   = exp_len(N);
  localparam int unsigned M   = man_len(N);
  localparam int unsigned W   = M + 5;
  localparam int unsigned ENC = enc_len(N);
  localparam int unsigned EX  = E + 2;
  localparam int unsigned RW  = M + 2;

  state_t         state, state_n;
  logic [N-1:0]   acc, acc_n, op, op_n, out_data_n;
  logic           last_q, last_n;
  logic           sign_a, sign_a_n, sign_b, sign_b_n, res_sign, res_sign_n;
  logic [E-1:0]   exp_a, exp_a_n;
  logic [W-1:0]   sig_a, sig_a_n, sig_b, sig_b_n, sum, sum_n;
  logic           in_ready_n, out_valid_n, busy_n;

  // Significand as {carry, hidden, mantissa, g, r, s}; zero exponent reads as zero.
  function automatic logic [W-1:0] sig_of(input logic [N-1:0] x);
    return (x[N-2 -: E] == '0) ? '0 : {2'b01, x[M-1:0], 3'b000};
  endfunction

  // ALIGN: order by exponent and shift the smaller operand into g/r/s.
  logic           op_big_c;
  logic [N-1:0]   big_c, small_c;
  logic [E-1:0]   diff_c;
  logic [W-1:0]   small_sig_c, shifted_c, lost_mask_c, aligned_c;

  always_comb begin
    op_big_c    = op[N-2 -: E] > acc[N-2 -: E];
    big_c       = op_big_c ? op : acc;
    small_c     = op_big_c ? acc : op;
    diff_c      = big_c[N-2 -: E] - small_c[N-2 -: E];
    small_sig_c = sig_of(small_c);
    shifted_c   = small_sig_c >> diff_c;
    lost_mask_c = ~({W{1'b1}} << diff_c);
    if (diff_c >= E'(M + 4))
      aligned_c = {{(W-1){1'b0}}, |small_sig_c};
    else
      aligned_c = {shifted_c[W-1:1], shifted_c[0] | (|(small_sig_c & lost_mask_c))};
  end

  // ADD: magnitude add or subtract; sign follows the larger magnitude.
  logic           eff_sub_c, a_ge_b_c, res_sign_c;
  logic [W-1:0]   sum_c;

  always_comb begin
    eff_sub_c = sign_a ^ sign_b;
    a_ge_b_c  = sig_a >= sig_b;
    if (!eff_sub_c) begin
      sum_c      = sig_a + sig_b;
      res_sign_c = sign_a;
    end else if (a_ge_b_c) begin
      sum_c      = sig_a - sig_b;
      res_sign_c = sign_a;
    end else begin
      sum_c      = sig_b - sig_a;
      res_sign_c = sign_b;
    end
  end

  // NORM: normalise, round to nearest even, then saturate or flush.
  logic [ENC-1:0] lz_c, shl_c;
  logic [W-2:0]   nrm_c;
  logic [EX-1:0]  nrm_exp_c, rnd_exp_c;
  logic           round_up_c;
  logic [RW-1:0]  rnd_c;
  logic [M-1:0]   man_c;
  logic [N-1:0]   result_c;

  lzc #(.WIDTH(W), .ENC(ENC)) u_lzc (.din(sum), .cnt_c(lz_c));

  always_comb begin
    shl_c = lz_c - ENC'(1);
    if (sum[W-1]) begin
      nrm_c     = {sum[W-1:2], sum[1] | sum[0]};
      nrm_exp_c = EX'(exp_a) + EX'(1);
    end else begin
      nrm_c     = sum[W-2:0] << shl_c;
      nrm_exp_c = EX'(exp_a) - EX'(shl_c);
    end
    round_up_c = nrm_c[2] & (nrm_c[1] | nrm_c[0] | nrm_c[3]);
    rnd_c      = {1'b0, nrm_c[W-2:3]} + RW'(round_up_c);
    rnd_exp_c  = nrm_exp_c + EX'(rnd_c[RW-1]);
    man_c      = rnd_c[RW-1] ? rnd_c[M:1] : rnd_c[M-1:0];
    if (sum == '0)
      result_c = '0;
    else if (rnd_exp_c[EX-1] || rnd_exp_c == '0)
      result_c = {res_sign, {(N-1){1'b0}}};
    else if (rnd_exp_c >= EX'({E{1'b1}}))
      result_c = {res_sign, {E{1'b1}}, {M{1'b0}}};
    else
      result_c = {res_sign, rnd_exp_c[E-1:0], man_c};
  end

  // Next-state and register updates.
  always_comb begin
    state_n    = state;
    acc_n      = acc;
    op_n       = op;
    last_n     = last_q;
    sign_a_n   = sign_a;
    sign_b_n   = sign_b;
    exp_a_n    = exp_a;
    sig_a_n    = sig_a;
    sig_b_n    = sig_b;
    sum_n      = sum;
    res_sign_n = res_sign;
    out_data_n = out_data;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_n    = in_data;
          last_n  = in_last;
          state_n = ALIGN;
        end
      end
      ALIGN: begin
        sign_a_n = big_c[N-1];
        exp_a_n  = big_c[N-2 -: E];
        sig_a_n  = sig_of(big_c);
        sign_b_n = small_c[N-1];
        sig_b_n  = aligned_c;
        state_n  = ADD;
      end
      ADD: begin
        sum_n      = sum_c;
        res_sign_n = res_sign_c;
        state_n    = NORM;
      end
      NORM: begin
        acc_n = result_c;
        if (last_q) begin
          out_data_n = result_c;
          state_n    = DONE;
        end else begin
          state_n = IDLE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          acc_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
    busy_n      = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      op        <= '0;
      last_q    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      exp_a     <= '0;
      sig_a     <= '0;
      sig_b     <= '0;
      sum       <= '0;
      res_sign  <= 1'b0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      op        <= op_n;
      last_q    <= last_n;
      sign_a    <= sign_a_n;
      sign_b    <= sign_b_n;
      exp_a     <= exp_a_n;
      sig_a     <= sig_a_n;
      sig_b     <= sig_b_n;
      sum       <= sum_n;
      res_sign  <= res_sign_n;
      out_data  <= out_data_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_fp_accum.sv
// Bench for fp_accum (N=32): directed cases plus random sums checked against an
// exact-integer model that rounds each partial sum to single precision.
module tb_fp_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic        out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc_cyc = 0;

  localparam int EMIN = 100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_accum #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // Value as an exact integer multiple of 2^(EMIN-150); zero exponent means zero.
  function automatic logic signed [127:0] to_grid(input logic [31:0] f);
    int e;
    logic signed [127:0] m;
    e = int'(f[30:23]);
    if (e == 0) return '0;
    m = '0;
    m[23:0] = {1'b1, f[22:0]};
    if (e >= EMIN) m = m << (e - EMIN);
    else m = m >> (EMIN - e);
    return f[31] ? -m : m;
  endfunction

  // Round an exact grid value to single precision, nearest-even.
  function automatic logic [31:0] from_grid(input logic signed [127:0] v);
    logic s;
    logic [127:0] mag, q, rem, half;
    int p, e, sh;
    if (v == 0) return 32'd0;
    s = (v < 0);
    mag = s ? 128'(-v) : 128'(v);
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = p + EMIN - 23;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh = p - 23;
      q = mag >> sh;
      rem = mag & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 128'd1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), q[22:0]};
  endfunction

  task automatic send(input logic [31:0] d, input logic l, output logic to);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        acc_cyc = cyc;
        @(posedge clk); #1;
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output logic to);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic get(output logic [31:0] r, output logic to);
    wait_out(to);
    r = out_data;
    if (!to) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic sum2(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] r, output logic to);
    logic t1, t2, t3;
    send(a, 1'b0, t1);
    send(b, 1'b1, t2);
    get(r, t3);
    to = t1 | t2 | t3;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL reset_flags: got %b expected 100", {in_ready, out_valid, busy});
    else passes++;
    checks++;
    if (out_data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", out_data);
    else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, busy} !== 2'b10) $display("FAIL idle_flags: got %b expected 10", {in_ready, busy});
    else passes++;
  endtask

  task automatic test_basic;
    logic to, t2;
    int t0;
    send(32'h3F80_0000, 1'b0, to);
    t0 = acc_cyc;
    checks++;
    if (to || {busy, in_ready} !== 2'b10)
      $display("FAIL basic_busy: got busy/in_ready %b (timeout %0b) expected 10", {busy, in_ready}, to);
    else passes++;
    send(32'h4000_0000, 1'b1, t2);
    wait_out(to);
    checks++;
    if (to || t2 || (cyc - t0) !== 8)
      $display("FAIL basic_latency: got %0d cycles expected 8", cyc - t0);
    else passes++;
    checks++;
    if (out_data !== 32'h4040_0000) $display("FAIL basic_sum: got %h expected 40400000", out_data);
    else passes++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL basic_release: got out_valid/in_ready %b expected 01", {out_valid, in_ready});
    else passes++;
  endtask

  task automatic test_directed;
    logic [31:0] r;
    logic to;
    sum2(32'h3FC0_0000, 32'hBFC0_0000, r, to);
    checks++;
    if (to || r !== 32'h0) $display("FAIL cancel: got %h expected 00000000", r);
    else passes++;
    sum2(32'h4B80_0000, 32'h3F80_0000, r, to);
    checks++;
    if (to || r !== 32'h4B80_0000) $display("FAIL tie_even: got %h expected 4b800000", r);
    else passes++;
    sum2(32'h7F7F_FFFF, 32'h7F7F_FFFF, r, to);
    checks++;
    if (to || r !== 32'h7F80_0000) $display("FAIL overflow: got %h expected 7f800000", r);
    else passes++;
  endtask

  task automatic test_zero_operand;
    logic [31:0] r;
    logic t1, t2, t3, t4;
    int waited;
    send(32'h3FC0_0000, 1'b0, t1);
    send(32'h0000_0123, 1'b0, t2);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (t2 || (cyc - acc_cyc) !== 4) $display("FAIL zero_latency: got %0d cycles expected 4", cyc - acc_cyc);
    else passes++;
    send(32'h8000_0000, 1'b1, t3);
    get(r, t4);
    checks++;
    if (t1 || t3 || t4 || r !== 32'h3FC0_0000) $display("FAIL zero_sum: got %h expected 3fc00000", r);
    else passes++;
  endtask

  task automatic test_backpressure;
    logic [31:0] r;
    logic t1, t2, t3, stable;
    send(32'h3F80_0000, 1'b1, t1);
    wait_out(t2);
    stable = !t1 && !t2;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000 || in_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!stable) $display("FAIL hold_stable: got out_valid %b data %h in_ready %b expected 1 3f800000 0",
                          out_valid, out_data, in_ready);
    else passes++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL single_handshake: got out_valid/in_ready %b expected 01", {out_valid, in_ready});
    else passes++;
    send(32'h4000_0000, 1'b1, t1);
    get(r, t3);
    checks++;
    if (t1 || t3 || r !== 32'h4000_0000) $display("FAIL fresh_sum: got %h expected 40000000", r);
    else passes++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    logic t1, t2, t3;
    send(32'h3F80_0000, 1'b0, t1);
    send(32'h4000_0000, 1'b0, t2);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'h0)
      $display("FAIL mid_reset_now: got flags %b data %h expected 100 00000000", {in_ready, out_valid, busy}, out_data);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 32'h0)
      $display("FAIL mid_reset_next: got flags %b data %h expected 100 00000000", {in_ready, out_valid, busy}, out_data);
    else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
    send(32'h4000_0000, 1'b1, t3);
    get(r, t1);
    checks++;
    if (t1 || t2 || t3 || r !== 32'h4000_0000) $display("FAIL after_reset_sum: got %h expected 40000000", r);
    else passes++;
  endtask

  task automatic test_random;
    logic [31:0] acc_w, op, r;
    logic to, t;
    int nops, sel;
    for (int s = 0; s < 20; s++) begin
      nops = int'($urandom_range(1, 4));
      acc_w = 32'h0;
      to = 1'b0;
      for (int k = 0; k < nops; k++) begin
        sel = int'($urandom_range(0, 9));
        if (sel == 0)
          op = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
        else if (sel == 1 && acc_w != 32'h0)
          op = acc_w ^ 32'h8000_0000;
        else
          op = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
        acc_w = from_grid(to_grid(acc_w) + to_grid(op));
        send(op, (k == nops - 1), t);
        to = to | t;
      end
      get(r, t);
      checks++;
      if (to || t || r !== acc_w) $display("FAIL random_sum[%0d]: got %h expected %h", s, r, acc_w);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_zero_operand();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
